apb_usrt_ctrl: RTL and testbench
================================

Name: apb_usrt_ctrl

Overview:
Parametrised APB slave with a synchronous serial (USRT) transmitter and receiver, buffered by TX and RX FIFOs. It generates the serial clock uClk from pClk through a programmable divider. Frame format is start bit 0, DATA_W data bits LSB first, optional parity, and stop bit 1. It sits between the APB interconnect and the off-chip serial link and replaces the fixed 8-bit, unbuffered USRT top level.

Parameters:
DATA_W, 8, APB data width and character width (min 8)
FIFO_DEPTH, 4, entries per TX and RX FIFO (power of 2, >=2)
ADDR_W, 4, APB address width; register select uses pAddress[3:2]
DIV_RESET, 39, reset value of DIV; uClk period = 2*(DIV+1) pClk cycles

Ports:
pClk  in  1  system/APB clock; all logic rising-edge
pReset  in  1  synchronous, active-high reset
pSelect  in  1  APB select
pEnable  in  1  APB enable (access phase)
pWrite  in  1  1 = write, 0 = read
pAddress  in  ADDR_W  byte address; 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC DIV
pWData  in  DATA_W  write data
pRData  out  DATA_W  read data; valid in access phase of a read, else 0
pReady  out  1  = pSelect & pEnable (zero wait states)
pSlvErr  out  1  access-phase error flag
uClk  out  1  serial clock
Tx  out  1  serial data out, idle 1
Rx  in  1  serial data in, synchronous to uClk
irq  out  1  level interrupt

Behaviour:
- Reset (one clock of pReset=1): FIFOs empty, CTRL=0, DIV=DIV_RESET, sticky flags 0, Tx=1, uClk=0, irq=0, both FSMs IDLE. Reset mid-frame abandons the frame; Tx=1 from the next edge.
- APB access: write or pop takes effect on the edge where pSelect&pEnable&pReady=1. The setup phase has no side effects.
- DATA write: pushes pWData to the TX FIFO. If the FIFO is full, the write is dropped and pSlvErr=1.
- DATA read: returns the RX FIFO head combinationally and pops it. If the FIFO is empty, it returns 0 and pSlvErr=1.
- STATUS read bits:
  - [0] tx_empty
  - [1] tx_full
  - [2] rx_empty
  - [3] rx_full
  - [4] parity_err
  - [5] frame_err
  - [6] overrun
- STATUS write: bits [6:4] are write-1-to-clear.
- CTRL read/write bits: [0] tx_en, [1] rx_en, [2] par_en, [3] par_odd, [4] irq_en.
- DIV: read/write. Writing DIV restarts the divider counter at 0.
- Unmapped offsets: read 0, write ignored, pSlvErr=0.
- Divider:
  - uClk runs only while tx_en|rx_en; otherwise the counter is held at 0 and uClk=0.
  - The counter counts 0..DIV. At DIV it wraps and toggles uClk.
  - rise_evt = cycle uClk goes 0->1; fall_evt = cycle uClk goes 1->0.
- TX FSM: states IDLE, START, DATA, PARITY, STOP. Transitions occur only on fall_evt.
  - IDLE: if tx_en and the FIFO is non-empty, pop into the shift register, Tx=0, go to START.
  - START -> DATA: shift out DATA_W bits, LSB first.
  - DATA -> PARITY if par_en, else STOP.
  - PARITY: Tx = XOR of data (even), inverted if par_odd.
  - STOP: Tx=1, then IDLE. Back-to-back frames are allowed: a new START is issued on the next fall_evt.
  - Clearing tx_en mid-frame completes the current frame.
- RX FSM: states IDLE, DATA, PARITY, STOP. Rx is sampled only on rise_evt while rx_en=1.
  - IDLE: Rx=0 -> DATA.
  - DATA: collect DATA_W bits, then PARITY (if par_en) or STOP.
  - Parity mismatch sets parity_err.
  - STOP: if Rx=0, set frame_err. In all cases push the character. If the RX FIFO is full, drop the character and set overrun.
  - Clearing rx_en forces IDLE immediately and discards the partial character.
- FIFOs: circular buffers with (log2 FIFO_DEPTH)+1-bit pointers; full/empty come from the pointer MSB compare.
  - A push and a pop in the same cycle are both honoured; a full TX FIFO accepts an APB push in the same cycle the TX FSM pops.
  - An APB pop from an empty FIFO in the same cycle as an RX push returns 0 with pSlvErr; the pushed character is kept.
- irq = irq_en & (~rx_empty | tx_empty | parity_err | frame_err | overrun), registered (one-cycle latency).
- Latency: a DATA write to an empty FIFO with an idle TX produces the start bit at the first fall_evt after the write.

Test Plan:
- Reset then read STATUS -> 0x05 (tx_empty, rx_empty); DIV reads 39; Tx=1; uClk=0.
- DIV=1, CTRL=0x01, write 0xA5 -> uClk period 4 pClk; Tx on successive fall_evt: 0,1,0,1,0,0,1,0,1,1; STATUS tx_empty=1 after stop.
- CTRL=0x0F (odd parity), loop Tx->Rx, write 0x3C -> parity bit 1; RX FIFO holds 0x3C; STATUS=0x01; DATA read returns 0x3C; second DATA read -> 0 with pSlvErr=1.
- Write 5 characters with FIFO_DEPTH=4 while tx_en=0 -> 5th write pSlvErr=1, tx_full=1; enable -> exactly 4 frames back-to-back, with no idle bit between a frame's stop bit and the next start bit.
- Drive 5 frames on Rx without reads -> overrun=1, FIFO holds first 4; write STATUS 0x40 -> overrun=0. Frame with stop=0 -> frame_err=1; irq=1 when irq_en=1.
- Assert pReset during a DATA bit of a TX frame -> Tx=1, FIFOs empty, CTRL=0 on the next cycle; no further frame output.

Source files
------------

// File: rtl/apb_usrt_ctrl.sv
// rtl/apb_usrt_ctrl.sv - APB slave USRT with TX/RX FIFOs and a programmable uClk divider
// Frame: start 0, DATA_W bits LSB first, optional parity, stop 1; Tx moves on uClk fall, Rx sampled on rise.

module apb_usrt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

module apb_usrt_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 4,
    parameter int DIV_RESET  = 39
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pSelect,
    input  logic              pEnable,
    input  logic              pWrite,
    input  logic [ADDR_W-1:0] pAddress,
    input  logic [DATA_W-1:0] pWData,
    output logic [DATA_W-1:0] pRData,
    output logic              pReady,
    output logic              pSlvErr,
    output logic              uClk,
    output logic              Tx,
    input  logic              Rx,
    output logic              irq
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic [1:0] REG_DATA = 2'd0, REG_STATUS = 2'd1, REG_CTRL = 2'd2, REG_DIV = 2'd3;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [4:0]        ctrl;
    logic [DATA_W-1:0] div;
    logic              parity_err, frame_err, overrun;
    logic              tx_en, rx_en, par_en, par_odd, irq_en;

    logic              access, mapped;
    logic [1:0]        sel;
    logic              data_wr, data_rd, status_wr, ctrl_wr, div_wr;

    logic [DATA_W-1:0] tx_head, rx_head;
    logic              tx_empty, tx_full, rx_empty, rx_full;

    tx_state_t         tx_state, tx_state_n;
    logic [DATA_W-1:0] tx_sh, tx_sh_n;
    logic [CW-1:0]     tx_cnt, tx_cnt_n;
    logic              tx_par, tx_par_n, tx_q, tx_n, tx_pop;

    rx_state_t         rx_state, rx_state_n;
    logic [DATA_W-1:0] rx_sh, rx_sh_n;
    logic [CW-1:0]     rx_cnt, rx_cnt_n;
    logic              rx_push, set_par, set_frame, set_ovr;

    logic [DATA_W-1:0] div_cnt;
    logic              uclk_q, run, wrap, rise_evt, fall_evt;

    assign {irq_en, par_odd, par_en, rx_en, tx_en} = ctrl;

    assign access    = pSelect & pEnable;
    assign pReady    = access;
    assign sel       = pAddress[3:2];
    assign mapped    = (pAddress[1:0] == 2'b00) && ((pAddress >> 4) == '0);
    assign data_wr   = access &  pWrite & mapped & (sel == REG_DATA);
    assign data_rd   = access & ~pWrite & mapped & (sel == REG_DATA);
    assign status_wr = access &  pWrite & mapped & (sel == REG_STATUS);
    assign ctrl_wr   = access &  pWrite & mapped & (sel == REG_CTRL);
    assign div_wr    = access &  pWrite & mapped & (sel == REG_DIV);
    assign pSlvErr   = (data_wr & tx_full & ~tx_pop) | (data_rd & rx_empty);
    assign set_ovr   = rx_push & rx_full & ~data_rd;

    always_comb begin
        pRData = '0;
        if (access && !pWrite && mapped) begin
            case (sel)
                REG_DATA:   if (!rx_empty) pRData = rx_head;
                REG_STATUS: pRData[6:0] = {overrun, frame_err, parity_err,
                                           rx_full, rx_empty, tx_full, tx_empty};
                REG_CTRL:   pRData[4:0] = ctrl;
                default:    pRData = div;
            endcase
        end
    end

    apb_usrt_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(pClk), .reset(pReset), .push(data_wr), .push_data(pWData),
        .pop(tx_pop), .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

    apb_usrt_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(pClk), .reset(pReset), .push(rx_push), .push_data(rx_sh),
        .pop(data_rd), .head(rx_head), .empty(rx_empty), .full(rx_full)
    );

    // The clock keeps running while a frame is in flight so that clearing tx_en can finish it.
    assign run      = tx_en | rx_en | (tx_state != TX_IDLE);
    assign wrap     = run & (div_cnt == div) & ~div_wr;
    assign rise_evt = wrap & ~uclk_q;
    assign fall_evt = wrap &  uclk_q;
    assign uClk     = uclk_q;
    assign Tx       = tx_q;

    always_ff @(posedge pClk) begin
        if (pReset || !run) begin
            div_cnt <= '0;
            uclk_q  <= 1'b0;
        end else if (div_wr) begin
            div_cnt <= '0;
        end else if (div_cnt == div) begin
            div_cnt <= '0;
            uclk_q  <= ~uclk_q;
        end else begin
            div_cnt <= div_cnt + DATA_W'(1);
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_sh_n    = tx_sh;
        tx_cnt_n   = tx_cnt;
        tx_par_n   = tx_par;
        tx_n       = tx_q;
        tx_pop     = 1'b0;
        if (fall_evt) begin
            case (tx_state)
                TX_IDLE, TX_STOP: begin
                    tx_n       = 1'b1;
                    tx_state_n = TX_IDLE;
                    if (tx_en && !tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_sh_n    = tx_head;
                        tx_par_n   = ^tx_head ^ par_odd;
                        tx_n       = 1'b0;
                        tx_state_n = TX_START;
                    end
                end
                TX_START: begin
                    tx_n       = tx_sh[0];
                    tx_sh_n    = tx_sh >> 1;
                    tx_cnt_n   = '0;
                    tx_state_n = TX_DATA;
                end
                TX_DATA: begin
                    if (tx_cnt == LAST) begin
                        tx_n       = par_en ? tx_par : 1'b1;
                        tx_state_n = par_en ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_n     = tx_sh[0];
                        tx_sh_n  = tx_sh >> 1;
                        tx_cnt_n = tx_cnt + CW'(1);
                    end
                end
                TX_PARITY: begin
                    tx_n       = 1'b1;
                    tx_state_n = TX_STOP;
                end
                default: tx_state_n = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_sh_n    = rx_sh;
        rx_cnt_n   = rx_cnt;
        rx_push    = 1'b0;
        set_par    = 1'b0;
        set_frame  = 1'b0;
        if (!rx_en) begin
            rx_state_n = RX_IDLE;
        end else if (rise_evt) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!Rx) begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = '0;
                    end
                end
                RX_DATA: begin
                    rx_sh_n  = {Rx, rx_sh[DATA_W-1:1]};
                    rx_cnt_n = rx_cnt + CW'(1);
                    if (rx_cnt == LAST) rx_state_n = par_en ? RX_PARITY : RX_STOP;
                end
                RX_PARITY: begin
                    set_par    = (Rx != (^rx_sh ^ par_odd));
                    rx_state_n = RX_STOP;
                end
                default: begin
                    set_frame  = ~Rx;
                    rx_push    = 1'b1;
                    rx_state_n = RX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            ctrl       <= '0;
            div        <= DATA_W'(DIV_RESET);
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            irq        <= 1'b0;
            tx_state   <= TX_IDLE;
            tx_sh      <= '0;
            tx_cnt     <= '0;
            tx_par     <= 1'b0;
            tx_q       <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_sh      <= '0;
            rx_cnt     <= '0;
        end else begin
            if (ctrl_wr) ctrl <= pWData[4:0];
            if (div_wr)  div  <= pWData;
            // A new error event wins over a simultaneous write-1-to-clear.
            parity_err <= set_par   | (parity_err & ~(status_wr & pWData[4]));
            frame_err  <= set_frame | (frame_err  & ~(status_wr & pWData[5]));
            overrun    <= set_ovr   | (overrun    & ~(status_wr & pWData[6]));
            irq        <= irq_en & (~rx_empty | tx_empty | parity_err | frame_err | overrun);
            tx_state   <= tx_state_n;
            tx_sh      <= tx_sh_n;
            tx_cnt     <= tx_cnt_n;
            tx_par     <= tx_par_n;
            tx_q       <= tx_n;
            rx_state   <= rx_state_n;
            rx_sh      <= rx_sh_n;
            rx_cnt     <= rx_cnt_n;
        end
    end
endmodule

// File: tb/tb_apb_usrt_ctrl.sv
// tb/tb_apb_usrt_ctrl.sv - directed self-checking bench for apb_usrt_ctrl
module tb_apb_usrt_ctrl;
    logic       pClk = 1'b0, pReset = 1'b1, pSelect = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
    logic [3:0] pAddress = '0;
    logic [7:0] pWData = '0;
    logic [7:0] pRData;
    logic       pReady, pSlvErr, uClk, Tx, Rx, irq;
    logic       rx_drv = 1'b1, loop = 1'b0, prev_u = 1'b0;
    logic       tx_q[$];
    int         fall_cnt = 0;
    int         errors = 0, checks = 0;

    assign Rx = loop ? Tx : rx_drv;

    apb_usrt_ctrl #(.DATA_W(8), .FIFO_DEPTH(4), .ADDR_W(4), .DIV_RESET(39)) dut (
        .pClk(pClk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable), .pWrite(pWrite),
        .pAddress(pAddress), .pWData(pWData), .pRData(pRData), .pReady(pReady), .pSlvErr(pSlvErr),
        .uClk(uClk), .Tx(Tx), .Rx(Rx), .irq(irq)
    );

    always #5 pClk = ~pClk;

    // Tx value captured after every uClk 1->0 transition
    always @(negedge pClk) begin
        if (prev_u && !uClk) begin
            tx_q.push_back(Tx);
            fall_cnt++;
        end
        prev_u = uClk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic apb_write(input logic [3:0] addr, input logic [7:0] data, output logic err);
        @(negedge pClk);
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddress = addr; pWData = data;
        @(negedge pClk);
        pEnable = 1'b1;
        #1 err = pSlvErr;
        @(negedge pClk);
        pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [7:0] data, output logic err);
        @(negedge pClk);
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddress = addr;
        @(negedge pClk);
        pEnable = 1'b1;
        #1 data = pRData; err = pSlvErr;
        @(negedge pClk);
        pSelect = 1'b0; pEnable = 1'b0;
    endtask

    task automatic wait_falls(input int n, input string what);
        int k = 0;
        while (tx_q.size() < n && k < 2000) begin
            @(negedge pClk);
            k++;
        end
        checks++;
        if (tx_q.size() < n) begin
            errors++;
            $display("FAIL %s: timeout with %0d uClk falls, required %0d", what, tx_q.size(), n);
        end
    endtask

    task automatic wait_fall();
        int start = fall_cnt;
        int k = 0;
        while (fall_cnt == start && k < 200) begin
            @(negedge pClk);
            #1 k++;
        end
        if (fall_cnt == start) begin
            checks++; errors++;
            $display("FAIL rx_drive: no uClk fall within 200 cycles");
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic stop);
        logic [9:0] f;
        f = {stop, c, 1'b0};
        for (int i = 0; i < 10; i++) begin
            wait_fall();
            rx_drv = f[i];
        end
        wait_fall();
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic e;
        pReset = 1'b1;
        repeat (2) @(negedge pClk);
        pReset = 1'b0;
        #1;
        checks++; if (Tx !== 1'b1)      begin errors++; $display("FAIL reset_tx: got %b want 1", Tx); end
        checks++; if (uClk !== 1'b0)    begin errors++; $display("FAIL reset_uclk: got %b want 0", uClk); end
        checks++; if (irq !== 1'b0)     begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (pReady !== 1'b0)  begin errors++; $display("FAIL idle_ready: got %b want 0", pReady); end
        checks++; if (pRData !== 8'h00) begin errors++; $display("FAIL idle_rdata: got %h want 00", pRData); end
        apb_read(4'h4, d, e);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL reset_status: got %h want 05", d); end
        apb_read(4'hC, d, e);
        checks++; if (d !== 8'd39) begin errors++; $display("FAIL reset_div: got %0d want 39", d); end
        apb_read(4'h8, d, e);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", d); end
    endtask

    task automatic test_unmapped();
        logic [7:0] d; logic e;
        apb_read(4'h1, d, e);
        checks++; if ({d, e} !== 9'h000) begin errors++; $display("FAIL unmapped_read: got %h err %b want 00 err 0", d, e); end
        apb_write(4'hA, 8'hFF, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL unmapped_write_err: got %b want 0", e); end
        apb_read(4'h8, d, e);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_write_ignored: ctrl %h want 00", d); end
    endtask

    task automatic test_tx_frame();
        logic [7:0] d; logic e; logic [9:0] obs; int f0;
        apb_write(4'hC, 8'd1, e);
        apb_write(4'h8, 8'h01, e);
        apb_write(4'h0, 8'hA5, e);
        #1 tx_q.delete();
        wait_falls(10, "tx_a5");
        for (int i = 0; i < 10; i++) obs[i] = tx_q[i];
        checks++; if (obs !== 10'b11_0100_1010) begin errors++; $display("FAIL tx_a5_bits: got %b want 1101001010 (bit0 first)", obs); end
        f0 = fall_cnt;
        repeat (40) @(negedge pClk);
        checks++; if (fall_cnt - f0 !== 10) begin errors++; $display("FAIL uclk_period: %0d falls in 40 cycles want 10", fall_cnt - f0); end
        apb_read(4'h4, d, e);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL tx_done_status: got %h want 05", d); end
    endtask

    task automatic test_parity_loop();
        logic [7:0] d; logic e; logic [10:0] obs;
        loop = 1'b1;
        apb_write(4'h8, 8'h0F, e);
        apb_write(4'h0, 8'h3C, e);
        #1 tx_q.delete();
        wait_falls(11, "tx_3c");
        for (int i = 0; i < 11; i++) obs[i] = tx_q[i];
        checks++; if (obs !== 11'b110_0111_1000) begin errors++; $display("FAIL tx_3c_bits: got %b want 11001111000 (bit0 first)", obs); end
        checks++; if (obs[9] !== 1'b1) begin errors++; $display("FAIL odd_parity_bit: got %b want 1", obs[9]); end
        repeat (8) @(negedge pClk);
        apb_read(4'h4, d, e);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL loop_status: got %h want 01", d); end
        apb_read(4'h0, d, e);
        checks++; if ({d, e} !== {8'h3C, 1'b0}) begin errors++; $display("FAIL loop_data: got %h err %b want 3c err 0", d, e); end
        apb_read(4'h0, d, e);
        checks++; if ({d, e} !== {8'h00, 1'b1}) begin errors++; $display("FAIL empty_read: got %h err %b want 00 err 1", d, e); end
        apb_write(4'h8, 8'h00, e);
        loop = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic e; logic [9:0] obs, exp;
        logic [7:0] chars [5];
        chars = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            apb_write(4'h0, chars[i], e);
            checks++; if (e !== (i == 4)) begin errors++; $display("FAIL push_err_%0d: got %b want %b", i, e, (i == 4)); end
        end
        apb_read(4'h4, d, e);
        checks++; if (d !== 8'h06) begin errors++; $display("FAIL full_status: got %h want 06", d); end
        apb_write(4'h8, 8'h01, e);
        #1 tx_q.delete();
        wait_falls(41, "b2b");
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 10; i++) obs[i] = tx_q[f*10 + i];
            exp = {1'b1, chars[f], 1'b0};
            checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_frame_%0d: got %b want %b", f, obs, exp); end
        end
        checks++; if (tx_q[40] !== 1'b1) begin errors++; $display("FAIL b2b_idle_after: got %b want 1", tx_q[40]); end
        apb_read(4'h4, d, e);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL b2b_drained: got %h want 05", d); end
        apb_write(4'h8, 8'h00, e);
    endtask

    task automatic test_rx_errors();
        logic [7:0] d; logic e;
        rx_drv = 1'b1;
        apb_write(4'h8, 8'h02, e);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        apb_read(4'h4, d, e);
        checks++; if (d !== 8'h49) begin errors++; $display("FAIL overrun_status: got %h want 49", d); end
        apb_write(4'h4, 8'h40, e);
        apb_read(4'h4, d, e);
        checks++; if (d !== 8'h09) begin errors++; $display("FAIL overrun_clear: got %h want 09", d); end
        for (int i = 1; i <= 4; i++) begin
            apb_read(4'h0, d, e);
            checks++; if ({d, e} !== {8'(i), 1'b0}) begin errors++; $display("FAIL rx_data_%0d: got %h err %b want %h err 0", i, d, e, 8'(i)); end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b want 0", irq); end
        send_frame(8'h5A, 1'b0);
        apb_read(4'h4, d, e);
        checks++; if (d !== 8'h21) begin errors++; $display("FAIL frame_err_status: got %h want 21", d); end
        apb_write(4'h8, 8'h12, e);
        repeat (2) @(negedge pClk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_enabled: got %b want 1", irq); end
        apb_read(4'h0, d, e);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL frame_err_data: got %h want 5a", d); end
        apb_write(4'h8, 8'h00, e);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d; logic e; int bad;
        apb_write(4'h8, 8'h01, e);
        apb_write(4'h0, 8'h00, e);
        apb_write(4'h0, 8'h00, e);
        #1 tx_q.delete();
        wait_falls(3, "pre_reset");
        @(negedge pClk) pReset = 1'b1;
        @(negedge pClk) pReset = 1'b0;
        #1;
        checks++; if (Tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b want 1", Tx); end
        apb_read(4'h4, d, e);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL mid_reset_status: got %h want 05", d); end
        apb_read(4'h8, d, e);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_reset_ctrl: got %h want 00", d); end
        apb_read(4'hC, d, e);
        checks++; if (d !== 8'd39) begin errors++; $display("FAIL mid_reset_div: got %0d want 39", d); end
        tx_q.delete();
        bad = 0;
        repeat (100) begin
            @(negedge pClk);
            if (Tx !== 1'b1 || uClk !== 1'b0) bad++;
        end
        checks++; if (bad != 0 || tx_q.size() != 0) begin errors++; $display("FAIL post_reset_quiet: %0d active samples, %0d falls, want 0", bad, tx_q.size()); end
    endtask

    initial begin
        test_reset();
        test_unmapped();
        test_tx_frame();
        test_parity_loop();
        test_back_to_back();
        test_rx_errors();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
